dff_pipe: RTL
=============

Name: dff_pipe

Overview:
Parametrised, enable-gated register pipeline: DEPTH stages of WIDTH-bit D flip-flops, each stage carrying a valid bit. It is the next generation of the team's single-bit enabled D flip-flop, generalised in width and depth, with valid tracking, synchronous clear and an occupancy counter. It is used as a stallable delay line for aligning datapaths.

Parameters:
WIDTH, 8, data bits per stage (>=1)
DEPTH, 4, number of stages (>=1); sets latency in enabled cycles
CNT_W, $clog2(DEPTH+1), occupancy counter width (derived; not overridden)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (asserted when 0)
en  input  1  advance pipeline one stage; 0 = stall/hold
clr  input  1  synchronous clear of all valids and data
d  input  WIDTH  data into stage 0
d_valid  input  1  valid qualifier for d
q  output  WIDTH  data of stage DEPTH-1
q_valid  output  1  valid bit of stage DEPTH-1
occ  output  CNT_W  number of stages currently holding valid data (0..DEPTH)
empty  output  1  occ==0 (combinational from occ)
full  output  1  occ==DEPTH (combinational from occ)

Behaviour:
- Reset (reset==0, async, any time): all stage data=0, all valids=0, occ=0; hence q=0, q_valid=0, empty=1, full=0. Release is sampled at the next rising clk edge.
- Priority at each rising edge: reset > clr > en > hold.
- clr=1: data[*]=0, valid[*]=0, occ=0 at that edge, regardless of en/d_valid.
- en=1, clr=0: stage0 <= {d,d_valid}; stage i <= stage i-1 for i=1..DEPTH-1. Data is captured regardless of d_valid (valid does not gate data).
- en=0, clr=0: every stage, valid and occ hold.
- Latency: d presented at enabled edge k appears on q at enabled edge k+DEPTH-1 (visible after it). Stalled cycles do not count. DEPTH=1 behaves as a DFF with enable plus a valid bit.
- occ on an enabled edge: occ_next = occ + d_valid - valid[DEPTH-1]. Simultaneous entry and exit leaves occ unchanged. occ never exceeds DEPTH and never underflows. Implementation must hold the invariant occ == popcount(valid[]).
- full does not block input. When full, the enabled edge drops the oldest entry out of q; this is a pipeline, not a FIFO.
- q and q_valid are registered outputs (no combinational path from d).
- No X propagation on outputs after reset, even if d is X while d_valid=0.

Optional Feature:
DFF_PIPE_TAP_EN:
- Defined: adds ports tap_sel (input, $clog2(DEPTH) bits, min 1) and tap_q/tap_valid (outputs, WIDTH/1). These are a combinational mux of stage[tap_sel]. tap_sel >= DEPTH returns 0/0.
- Undefined: ports are absent and no mux logic is generated.

Decomposition:
- Package dff_pipe_pkg: function clog2_min1(n) (returns >=1), and localparam default WIDTH/DEPTH values shared with the bench.
- Sub-module dff_en_stage: one WIDTH+1-bit register with clk, reset (async active-low), en, clr. It is instantiated DEPTH times via generate. The occupancy counter lives in the top.

Test Plan:
1. WIDTH=8, DEPTH=4. Hold reset=0 for 2 clocks with d=8'hFF, d_valid=1, en=1 -> q=0, q_valid=0, occ=0, empty=1 throughout.
2. Release reset; en=1; feed 8'h11,22,33,44,55 all valid -> q=8'h11 with q_valid=1 after the 4th edge, then 22..55 on successive edges. occ sequence is 1,2,3,4,4; full=1 from the 4th edge.
3. With the pipe holding 11..44, drop en=0 for 3 cycles while d toggles -> q, occ and all stages unchanged. Raise en=1 -> shifting resumes from 8'h11.
4. Pipe full, then assert clr=1 and en=1 for one edge with d_valid=1 -> next cycle occ=0, q=0, q_valid=0, empty=1.
5. Feed alternating d_valid=1/0 with d=8'hA0+i -> occ settles at 2. q_valid pattern is 1,0,1,0, and q carries invalid data unmodified.
6. Mid-stream (occ=3), pull reset low between clock edges -> outputs go to 0 and occ to 0 immediately, without waiting for clk. With DFF_PIPE_TAP_EN defined, tap_sel=2 shows the stage-2 value during step 2.

Source files
------------

// File: rtl/dff_pipe_pkg.sv
// -----------------------------------------------------------------------------
// dff_pipe_pkg
// Shared definitions for the dff_pipe stallable delay line.
//   DEF_WIDTH  : default data bits per stage
//   DEF_DEPTH  : default number of stages
//   clog2_min1 : ceil(log2(n)) clamped to at least 1, for select and counter
//                widths that must stay legal when DEPTH is 1
// -----------------------------------------------------------------------------
package dff_pipe_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 4;

   // Width helper that never returns 0, so a 1-stage pipe still gets a 1-bit bus.
   function automatic int clog2_min1(input int n);
      int r;
      if (n > 2) begin
         r = $clog2(n);
      end else begin
         r = 1;
      end
      return r;
   endfunction

endpackage : dff_pipe_pkg

// File: rtl/dff_en_stage.sv
// -----------------------------------------------------------------------------
// dff_en_stage
// One pipeline stage: a W-bit register with enable and synchronous clear.
// The top packs {data, valid} into this register.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset (register -> 0)
//   en    : load d at the edge; 0 = hold
//   clr   : synchronous clear, overrides en
//   d     : next-stage input
//   q     : registered stage contents
// -----------------------------------------------------------------------------
module dff_en_stage
   import dff_pipe_pkg::*;
#(
   parameter int W = DEF_WIDTH + 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic         clr,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] r_q;

   // Stage register: reset > clr > en > hold.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_q <= '0;
      end else if (clr) begin
         r_q <= '0;
      end else if (en) begin
         r_q <= d;
      end else begin
         r_q <= r_q;
      end
   end

   assign q = r_q;

endmodule : dff_en_stage

// File: rtl/dff_pipe.sv
// -----------------------------------------------------------------------------
// dff_pipe
// Enable-gated register pipeline of DEPTH stages, WIDTH data bits each, with a
// valid bit per stage, synchronous clear and an occupancy counter. Used as a
// stallable delay line; it never back-pressures (full does not block input,
// the oldest entry simply leaves through q on the next enabled edge).
//
// Parameters:
//   WIDTH : data bits per stage (>=1)
//   DEPTH : number of stages (>=1), latency in enabled cycles
//   CNT_W : occupancy counter width, derived from DEPTH
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-low reset
//   en        in   advance one stage; 0 = stall
//   clr       in   synchronous clear of all data and valids
//   d         in   WIDTH data into stage 0 (captured even when d_valid=0)
//   d_valid   in   valid qualifier for d
//   q         out  WIDTH data of the last stage (registered)
//   q_valid   out  valid bit of the last stage (registered)
//   occ       out  CNT_W number of stages holding valid data
//   empty     out  occ == 0
//   full      out  occ == DEPTH
//
// Optional build macro DFF_PIPE_TAP_EN adds:
//   tap_sel   in   TAP_W stage select
//   tap_q     out  WIDTH data of stage[tap_sel] (0 when tap_sel >= DEPTH)
//   tap_valid out  valid of stage[tap_sel]    (0 when tap_sel >= DEPTH)
// -----------------------------------------------------------------------------
module dff_pipe
   import dff_pipe_pkg::*;
#(
   parameter  int WIDTH = DEF_WIDTH,
   parameter  int DEPTH = DEF_DEPTH,
   localparam int CNT_W = clog2_min1(DEPTH + 1)
`ifdef DFF_PIPE_TAP_EN
   ,
   localparam int TAP_W = clog2_min1(DEPTH)
`endif
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             clr,
   input  logic [WIDTH-1:0] d,
   input  logic             d_valid,
`ifdef DFF_PIPE_TAP_EN
   input  logic [TAP_W-1:0] tap_sel,
   output logic [WIDTH-1:0] tap_q,
   output logic             tap_valid,
`endif
   output logic [WIDTH-1:0] q,
   output logic             q_valid,
   output logic [CNT_W-1:0] occ,
   output logic             empty,
   output logic             full
);

   localparam int SW = WIDTH + 1;   // stage word: {data, valid}

   logic [DEPTH-1:0][SW-1:0] w_stage_d;
   logic [DEPTH-1:0][SW-1:0] w_stage_q;
   logic                     w_last_valid;
   logic [CNT_W-1:0]         r_occ;
   logic [CNT_W-1:0]         w_occ_next;

   // ---------------------------------------------------------------------------
   // Stage chain: stage 0 takes {d, d_valid}, stage i takes stage i-1.
   // ---------------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_stage
         if (gi == 0) begin : g_head
            assign w_stage_d[gi] = {d, d_valid};
         end else begin : g_body
            assign w_stage_d[gi] = w_stage_q[gi-1];
         end

         dff_en_stage #(
            .W (SW)
         ) u_stage (
            .clk   (clk),
            .reset (reset),
            .en    (en),
            .clr   (clr),
            .d     (w_stage_d[gi]),
            .q     (w_stage_q[gi])
         );
      end
   endgenerate

   assign w_last_valid = w_stage_q[DEPTH-1][0];

   // ---------------------------------------------------------------------------
   // Occupancy: tracks popcount of the valid bits incrementally. An entry
   // arriving and one leaving on the same edge cancel. The range guards keep
   // the counter inside 0..DEPTH even if a stage were disturbed.
   // ---------------------------------------------------------------------------

   // Next occupancy from clear / shift in / shift out.
   always_comb begin
      w_occ_next = r_occ;
      if (clr) begin
         w_occ_next = '0;
      end else if (en) begin
         case ({d_valid, w_last_valid})
            2'b10: begin
               if (r_occ != CNT_W'(DEPTH)) begin
                  w_occ_next = r_occ + CNT_W'(1);
               end else begin
                  w_occ_next = r_occ;
               end
            end
            2'b01: begin
               if (r_occ != '0) begin
                  w_occ_next = r_occ - CNT_W'(1);
               end else begin
                  w_occ_next = r_occ;
               end
            end
            default: w_occ_next = r_occ;
         endcase
      end else begin
         w_occ_next = r_occ;
      end
   end

   // Occupancy register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_occ <= '0;
      end else begin
         r_occ <= w_occ_next;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs: q/q_valid come straight from the last stage register.
   // ---------------------------------------------------------------------------
   assign q       = w_stage_q[DEPTH-1][SW-1:1];
   assign q_valid = w_last_valid;
   assign occ     = r_occ;
   assign empty   = (r_occ == '0);
   assign full    = (r_occ == CNT_W'(DEPTH));

`ifdef DFF_PIPE_TAP_EN
   // Tap mux: compare against each legal index so out-of-range selects fall
   // through to 0 without ever indexing past the stage array.
   always_comb begin
      tap_q     = '0;
      tap_valid = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (tap_sel == TAP_W'(i)) begin
            tap_q     = w_stage_q[i][SW-1:1];
            tap_valid = w_stage_q[i][0];
         end else begin
            tap_q     = tap_q;
            tap_valid = tap_valid;
         end
      end
   end
`endif

endmodule : dff_pipe
